// File: rtl/matrix_stream_tiler_pkg.sv
// Shared types and sizing helpers for the matrix stream tiler.
package matrix_stream_tiler_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  function automatic int tile_count(int total, int compute);
    return total / compute;
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_stream_tiler_if.sv
// Row-segment input and tile output handshake bundle.
interface matrix_stream_tiler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2
) ();
  logic [DATA_WIDTH*COMPUTE_DIM0-1:0]              in_data;
  logic                                            in_valid;
  logic                                            in_ready;
  logic [DATA_WIDTH*COMPUTE_DIM0*COMPUTE_DIM1-1:0] out_data;
  logic                                            out_valid;
  logic                                            out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/matrix_stream_tiler_tile_row_bank.sv
// One tile row of storage: segment write port, whole-tile read port.
module tile_row_bank
  import matrix_stream_tiler_pkg::*;
#(
  parameter int TILES_X      = 2,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [cnt_width(TILES_X)-1:0]        wr_xc,
  input  logic [cnt_width(COMPUTE_DIM1)-1:0]   wr_r,
  input  logic [DATA_WIDTH*COMPUTE_DIM0-1:0]   wr_seg,
  input  logic [cnt_width(TILES_X)-1:0]        rd_tx,
  output logic [DATA_WIDTH*COMPUTE_DIM0*COMPUTE_DIM1-1:0] rd_tile
);
  localparam int SW = DATA_WIDTH * COMPUTE_DIM0;
  localparam int NE = TILES_X * COMPUTE_DIM1;
  localparam int AW = cnt_width(NE);

  logic [SW-1:0] mem_q [NE];
  logic [SW-1:0] mem_d [NE];
  logic [AW-1:0] wr_idx;

  assign wr_idx = AW'(int'(wr_xc) * COMPUTE_DIM1 + int'(wr_r));

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_idx] = wr_seg;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Tile row r sits at element offset r*COMPUTE_DIM0 of the flat tile.
  always_comb begin
    rd_tile = '0;
    for (int r = 0; r < COMPUTE_DIM1; r++) begin
      rd_tile[r*SW +: SW] = mem_q[AW'(int'(rd_tx) * COMPUTE_DIM1 + r)];
    end
  end
endmodule

// File: rtl/matrix_stream_tiler.sv
// Re-chunks a row-major segment stream into tiles via two
// ping-pong tile-row banks.
module matrix_stream_tiler
  import matrix_stream_tiler_pkg::*;
#(
  parameter int TOTAL_DIM0   = 4,
  parameter int TOTAL_DIM1   = 4,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2,
  parameter int DATA_WIDTH   = 8
) (
  input logic                  clk,
  input logic                  rst,
  matrix_stream_tiler_if.slave bus
);
  localparam int TX = tile_count(TOTAL_DIM0, COMPUTE_DIM0);
  localparam int TY = tile_count(TOTAL_DIM1, COMPUTE_DIM1);
  localparam int XW = cnt_width(TX);
  localparam int RW = cnt_width(COMPUTE_DIM1);
  localparam int TW = DATA_WIDTH * COMPUTE_DIM0 * COMPUTE_DIM1;

  if (TX * COMPUTE_DIM0 != TOTAL_DIM0 ||
      TY * COMPUTE_DIM1 != TOTAL_DIM1) begin : g_bad_dims
    $fatal(1, "matrix dims not a multiple of tile dims");
  end

  logic [XW-1:0] wr_xc_q, wr_xc_d;
  logic [RW-1:0] wr_r_q, wr_r_d;
  logic [XW-1:0] tx_q, tx_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];

  logic          wr_fire, rd_fire;
  logic [TW-1:0] tile_w [2];

  assign bus.in_ready  = (bank_q[wr_sel_q] == BANK_EMPTY);
  assign bus.out_valid = (bank_q[rd_sel_q] == BANK_FULL);
  assign bus.out_data  = tile_w[rd_sel_q];
  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = bus.out_valid && bus.out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_row_bank #(
      .TILES_X      (TX),
      .COMPUTE_DIM0 (COMPUTE_DIM0),
      .COMPUTE_DIM1 (COMPUTE_DIM1),
      .DATA_WIDTH   (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .we      (wr_fire && (wr_sel_q == 1'(b))),
      .wr_xc   (wr_xc_q),
      .wr_r    (wr_r_q),
      .wr_seg  (bus.in_data),
      .rd_tx   (tx_q),
      .rd_tile (tile_w[b])
    );
  end

  // Write fills one bank while the other drains; they never
  // touch the same bank in one cycle (EMPTY vs FULL).
  always_comb begin
    wr_xc_d  = wr_xc_q;
    wr_r_d   = wr_r_q;
    tx_d     = tx_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    bank_d   = bank_q;
    if (wr_fire) begin
      if (wr_xc_q == XW'(TX - 1)) begin
        wr_xc_d = '0;
        if (wr_r_q == RW'(COMPUTE_DIM1 - 1)) begin
          wr_r_d           = '0;
          bank_d[wr_sel_q] = BANK_FULL;
          wr_sel_d         = ~wr_sel_q;
        end else begin
          wr_r_d = wr_r_q + RW'(1);
        end
      end else begin
        wr_xc_d = wr_xc_q + XW'(1);
      end
    end
    if (rd_fire) begin
      if (tx_q == XW'(TX - 1)) begin
        tx_d             = '0;
        bank_d[rd_sel_q] = BANK_EMPTY;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        tx_d = tx_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_xc_q  <= '0;
      wr_r_q   <= '0;
      tx_q     <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      bank_q   <= '{BANK_EMPTY, BANK_EMPTY};
    end else begin
      wr_xc_q  <= wr_xc_d;
      wr_r_q   <= wr_r_d;
      tx_q     <= tx_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      bank_q   <= bank_d;
    end
  end
endmodule

// File: tb/tb_matrix_stream_tiler.sv
// Testbench for matrix_stream_tiler: vector table, stall/release,
// random scoreboard, mid-stream reset and a 4x2-tile instance.
module tb_matrix_stream_tiler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_stream_tiler_if #(
    .DATA_WIDTH(8), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2)
  ) bus ();
  matrix_stream_tiler_if #(
    .DATA_WIDTH(8), .COMPUTE_DIM0(4), .COMPUTE_DIM1(2)
  ) bus2 ();

  matrix_stream_tiler #(
    .TOTAL_DIM0(4), .TOTAL_DIM1(4),
    .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .DATA_WIDTH(8)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  matrix_stream_tiler #(
    .TOTAL_DIM0(8), .TOTAL_DIM1(4),
    .COMPUTE_DIM0(4), .COMPUTE_DIM1(2), .DATA_WIDTH(8)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;
  int tiles_seen = 0;
  bit mon_en = 1'b0;
  bit rnd_on = 1'b0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_tile;
  } vec_t;
  vec_t vecs [11];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // element(y,x) = base + 4y + x for the 4x4 / 2x2 instance
  function automatic logic [15:0] beat_of(int base, int k);
    int y;
    int xc;
    y  = k / 2;
    xc = k % 2;
    return {8'(base + 4*y + 2*xc + 1), 8'(base + 4*y + 2*xc)};
  endfunction

  function automatic logic [31:0] tile_of(int base, int ty, int tx);
    logic [31:0] t;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        t[(r*2+c)*8 +: 8] = 8'(base + 4*(2*ty + r) + 2*tx + c);
    return t;
  endfunction

  task automatic push_matrix(int base);
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 2; tx++)
        exp_q.push_back(tile_of(base, ty, tx));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send_beat(logic [15:0] data, int max_gap);
    int n;
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (6) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      tiles_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected none", bus.out_data);
      end else begin
        check("sb_tile", 64'(bus.out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen0;
    int n2;
    logic [63:0] exp2;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    for (int i = 0; i < 11; i++) begin
      vecs[i].in_valid  = (i < 8);
      vecs[i].in_data   = (i < 8) ? beat_of(0, i) : 16'h0;
      vecs[i].exp_ready = 1'b1;
      vecs[i].exp_valid = (i == 4 || i == 5 || i == 8 || i == 9);
      vecs[i].exp_tile  = (i == 4) ? tile_of(0, 0, 0) :
                          (i == 5) ? tile_of(0, 0, 1) :
                          (i == 8) ? tile_of(0, 1, 0) :
                          (i == 9) ? tile_of(0, 1, 1) : 32'h0;
    end

    // Table: one matrix, out_ready=1, back-to-back beats
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = vecs[i].in_valid;
      bus.in_data  = vecs[i].in_data;
      @(negedge clk);
      check("vec_in_ready", 64'(bus.in_ready), 64'(vecs[i].exp_ready));
      check("vec_out_valid", 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check("vec_tile", 64'(bus.out_data), 64'(vecs[i].exp_tile));
    end

    // Stall: out_ready=0 while offering two matrices
    do_reset();
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = beat_of((k < 8) ? 0 : 16, k % 8);
      @(negedge clk);
      if (k >= 8) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_tile", 64'(bus.out_data), 64'(tile_of(0, 0, 0)));
      end else if (bus.in_ready) begin
        k++;
      end
    end
    check("stall_beats", 64'(k), 64'd8);

    // Release: first tile row drains, in_ready returns one cycle later
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("rel0_tile", 64'(bus.out_data), 64'(tile_of(0, 0, 0)));
    check("rel0_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rel1_valid", 64'(bus.out_valid), 64'd1);
    check("rel1_tile", 64'(bus.out_data), 64'(tile_of(0, 0, 1)));
    check("rel1_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(tile_of(0, 1, 0));
    exp_q.push_back(tile_of(0, 1, 1));
    push_matrix(16);
    mon_en = 1'b1;
    @(negedge clk);
    check("rel2_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) send_beat(beat_of(16, b), 0);
    wait_drain(200);
    mon_en = 1'b0;

    // Random valid/ready over 100 matrices
    do_reset();
    mon_en = 1'b1;
    seen0 = tiles_seen;
    rnd_on = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 0; m < 100; m++) begin
      push_matrix((m * 16) % 256);
      for (int b = 0; b < 8; b++) send_beat(beat_of((m * 16) % 256, b), 1);
    end
    wait_drain(2000);
    rnd_on = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    check("rnd_tile_count", 64'(tiles_seen - seen0), 64'd400);
    mon_en = 1'b0;

    // Reset after 3 beats of stale data, then a fresh matrix
    do_reset();
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) send_beat(beat_of(8'hA0, b), 0);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    mon_en = 1'b1;
    push_matrix(0);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) send_beat(beat_of(0, b), 0);
    wait_drain(200);
    mon_en = 1'b0;

    // 8x4 matrix, 4x2 tiles: first tile row, element(y,x) = 8y+x
    n2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      bus2.in_valid = (c < 4);
      for (int e = 0; e < 4; e++)
        bus2.in_data[e*8 +: 8] = 8'(8*(c/2) + 4*(c%2) + e);
      @(negedge clk);
      if (bus2.out_valid) begin
        for (int r = 0; r < 2; r++)
          for (int e = 0; e < 4; e++)
            exp2[(r*4+e)*8 +: 8] = 8'(8*r + 4*n2 + e);
        if (n2 < 2) check("wide_tile", bus2.out_data, exp2);
        n2++;
      end
    end
    check("wide_count", 64'(n2), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
